multi_edge_detector: RTL and testbench

//  Per-channel edge detector for NUM_CH asynchronous or slow control inputs (SYNC, SYSREF

---
 rtl/multi_edge_detector_if.sv | 43 ++++
 rtl/multi_edge_detector.sv | 130 +++++++++++++
 tb/tb_multi_edge_detector.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/multi_edge_detector_if.sv
// Bundled channel signals of multi_edge_detector; the master side drives inputs, the slave is the detector.
// cnt_o exists only when EDGE_DET_COUNTERS_EN is defined.
interface multi_edge_detector_if #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 16
);
    logic [NUM_CH-1:0]   signal_i;
    logic [2*NUM_CH-1:0] mode_i;
    logic [NUM_CH-1:0]   clear_i;
    logic [NUM_CH-1:0]   level_o;
    logic [NUM_CH-1:0]   posedge_pulse_o;
    logic [NUM_CH-1:0]   negedge_pulse_o;
    logic [NUM_CH-1:0]   event_o;
    logic [NUM_CH-1:0]   sticky_o;
    logic                any_event_o;
`ifdef EDGE_DET_COUNTERS_EN
    logic [NUM_CH*CNT_W-1:0] cnt_o;

    modport master (
        output signal_i, mode_i, clear_i,
        input  level_o, posedge_pulse_o, negedge_pulse_o, event_o, sticky_o, any_event_o, cnt_o
    );

    modport slave (
        input  signal_i, mode_i, clear_i,
        output level_o, posedge_pulse_o, negedge_pulse_o, event_o, sticky_o, any_event_o, cnt_o
    );
`else
    modport master (
        output signal_i, mode_i, clear_i,
        input  level_o, posedge_pulse_o, negedge_pulse_o, event_o, sticky_o, any_event_o
    );

    modport slave (
        input  signal_i, mode_i, clear_i,
        output level_o, posedge_pulse_o, negedge_pulse_o, event_o, sticky_o, any_event_o
    );
`endif

    if (NUM_CH < 1 || CNT_W < 1) begin : g_bad_params
        $error("multi_edge_detector_if: NUM_CH and CNT_W must be at least 1");
    end
endinterface

// File: rtl/multi_edge_detector.sv
// Per-channel synchronizer, glitch filter and level tracker producing edge pulses, mode-gated
// events and sticky flags. Define EDGE_DET_COUNTERS_EN to add saturating per-channel event counters.
module multi_edge_detector #(
    parameter int NUM_CH        = 4,
    parameter int SYNC_STAGES   = 2,
    parameter int FILTER_CYCLES = 0,
    parameter bit INIT_LEVEL    = 1'b0,
    parameter int CNT_W         = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    multi_edge_detector_if.slave  bus
);
    localparam int FILTER_MAX = (FILTER_CYCLES > 1) ? FILTER_CYCLES : 1;
    localparam int FCNT_RAW   = $clog2(FILTER_CYCLES + 1);
    localparam int FCNT_W     = (FCNT_RAW > 0) ? FCNT_RAW : 1;
    localparam logic [FCNT_W-1:0] FCNT_LAST = FCNT_W'(FILTER_MAX - 1);
    localparam logic [NUM_CH-1:0] INIT_VEC  = {NUM_CH{INIT_LEVEL}};

    logic [NUM_CH-1:0] sync_out;
    logic [NUM_CH-1:0] level_q;
    logic [NUM_CH-1:0] prev_q;
    logic [NUM_CH-1:0] sticky_q;
    logic [FCNT_W-1:0] fcnt_q [NUM_CH];
    logic [NUM_CH-1:0] pos_edge;
    logic [NUM_CH-1:0] neg_edge;
    logic [NUM_CH-1:0] event_hit;

    if (NUM_CH < 1 || SYNC_STAGES < 0 || SYNC_STAGES > 4 || FILTER_CYCLES < 0 || CNT_W < 1)
    begin : g_bad_params
        $error("multi_edge_detector: parameter out of range");
    end

    if (SYNC_STAGES == 0) begin : g_no_sync
        assign sync_out = bus.signal_i;
    end else begin : g_sync
        logic [NUM_CH-1:0] chain_q [SYNC_STAGES];

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                for (int i = 0; i < SYNC_STAGES; i++) begin
                    chain_q[i] <= INIT_VEC;
                end
            end else begin
                chain_q[0] <= bus.signal_i;
                for (int i = 1; i < SYNC_STAGES; i++) begin
                    chain_q[i] <= chain_q[i-1];
                end
            end
        end

        assign sync_out = chain_q[SYNC_STAGES-1];
    end

    // A new level is accepted only after FILTER_MAX consecutive mismatching samples;
    // any matching sample restarts the count, so short glitches never reach level_q.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            level_q <= INIT_VEC;
            prev_q  <= INIT_VEC;
            for (int c = 0; c < NUM_CH; c++) begin
                fcnt_q[c] <= '0;
            end
        end else begin
            prev_q <= level_q;
            for (int c = 0; c < NUM_CH; c++) begin
                if (sync_out[c] == level_q[c]) begin
                    fcnt_q[c] <= '0;
                end else if (fcnt_q[c] == FCNT_LAST) begin
                    level_q[c] <= sync_out[c];
                    fcnt_q[c]  <= '0;
                end else begin
                    fcnt_q[c] <= fcnt_q[c] + FCNT_W'(1);
                end
            end
        end
    end

    always_comb begin
        pos_edge  = level_q & ~prev_q;
        neg_edge  = ~level_q & prev_q;
        event_hit = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            event_hit[c] = (pos_edge[c] & bus.mode_i[2*c]) | (neg_edge[c] & bus.mode_i[2*c+1]);
        end
    end

    // Set wins over clear so an event arriving with clear_i is never lost.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sticky_q <= '0;
        end else begin
            sticky_q <= event_hit | (sticky_q & ~bus.clear_i);
        end
    end

    assign bus.level_o         = level_q;
    assign bus.posedge_pulse_o = pos_edge;
    assign bus.negedge_pulse_o = neg_edge;
    assign bus.event_o         = event_hit;
    assign bus.sticky_o        = sticky_q;
    assign bus.any_event_o     = |event_hit;

`ifdef EDGE_DET_COUNTERS_EN
    localparam logic [CNT_W-1:0] CNT_SAT = '1;

    logic [CNT_W-1:0] cnt_q [NUM_CH];

    // Clearing in the same cycle as an event leaves a count of one for that event.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int c = 0; c < NUM_CH; c++) begin
                cnt_q[c] <= '0;
            end
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (bus.clear_i[c]) begin
                    cnt_q[c] <= event_hit[c] ? CNT_W'(1) : '0;
                end else if (event_hit[c] && (cnt_q[c] != CNT_SAT)) begin
                    cnt_q[c] <= cnt_q[c] + CNT_W'(1);
                end
            end
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_cnt_out
        assign bus.cnt_o[c*CNT_W +: CNT_W] = cnt_q[c];
    end
`endif
endmodule

// File: tb/tb_multi_edge_detector.sv
// Checks two multi_edge_detector configurations (SYNC=2/FILTER=0 and SYNC=1/FILTER=4) against a
// sample-window reference model, with directed edge cases followed by randomized traffic.
module tb_multi_edge_detector;
    localparam int NCH    = 4;
    localparam int CW     = 4;
    localparam int SYNC_A = 2;
    localparam int FILT_A = 0;
    localparam int SYNC_B = 1;
    localparam int FILT_B = 4;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    multi_edge_detector_if #(.NUM_CH(NCH), .CNT_W(CW)) bus_a ();
    multi_edge_detector_if #(.NUM_CH(NCH), .CNT_W(CW)) bus_b ();

    multi_edge_detector #(
        .NUM_CH(NCH), .SYNC_STAGES(SYNC_A), .FILTER_CYCLES(FILT_A), .INIT_LEVEL(1'b0), .CNT_W(CW)
    ) dut_a (
        .clk_i(clk), .rst_i(rst), .bus(bus_a)
    );

    multi_edge_detector #(
        .NUM_CH(NCH), .SYNC_STAGES(SYNC_B), .FILTER_CYCLES(FILT_B), .INIT_LEVEL(1'b0), .CNT_W(CW)
    ) dut_b (
        .clk_i(clk), .rst_i(rst), .bus(bus_b)
    );

    int pass_cnt  = 0;
    int fail_cnt  = 0;
    int check_cnt = 0;
    bit model_valid = 1'b0;

    // Model state: raw sample delay line, window of recent filter inputs, accepted level history.
    bit [3:0] m_pipe [2][NCH];
    bit [7:0] m_win  [2][NCH];
    int       m_wlen [2][NCH];
    bit       m_lvl  [2][NCH];
    bit       m_prv  [2][NCH];
    bit       m_stk  [2][NCH];
    int       m_cnt  [2][NCH];

    task automatic compare(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        check_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic bit m_event(input int d, input int c, input logic [2*NCH-1:0] mode);
        bit pos;
        bit neg;
        pos = m_lvl[d][c] && !m_prv[d][c];
        neg = !m_lvl[d][c] && m_prv[d][c];
        return (pos && mode[2*c] === 1'b1) || (neg && mode[2*c+1] === 1'b1);
    endfunction

    task automatic model_reset(input int d);
        for (int c = 0; c < NCH; c++) begin
            m_pipe[d][c] = '0;
            m_win[d][c]  = '0;
            m_wlen[d][c] = 0;
            m_lvl[d][c]  = 1'b0;
            m_prv[d][c]  = 1'b0;
            m_stk[d][c]  = 1'b0;
            m_cnt[d][c]  = 0;
        end
    endtask

    // A level flips once the last max(FILTER,1) filter inputs all differ from it.
    task automatic model_clock(input int d, input logic [NCH-1:0] sig,
                               input logic [2*NCH-1:0] mode, input logic [NCH-1:0] clr);
        int s;
        int fm;
        bit ev;
        bit used;
        bit flip;
        s  = (d == 0) ? SYNC_A : SYNC_B;
        fm = (d == 0) ? FILT_A : FILT_B;
        if (fm < 1) fm = 1;
        for (int c = 0; c < NCH; c++) begin
            ev = m_event(d, c, mode);
            m_stk[d][c] = ev || (m_stk[d][c] && clr[c] !== 1'b1);
            if (clr[c] === 1'b1) m_cnt[d][c] = ev ? 1 : 0;
            else if (ev && m_cnt[d][c] < (1 << CW) - 1) m_cnt[d][c] = m_cnt[d][c] + 1;
            if (s == 0) used = sig[c];
            else used = m_pipe[d][c][s-1];
            m_pipe[d][c] = {m_pipe[d][c][2:0], sig[c]};
            m_win[d][c]  = {m_win[d][c][6:0], used};
            if (m_wlen[d][c] < 8) m_wlen[d][c] = m_wlen[d][c] + 1;
            m_prv[d][c] = m_lvl[d][c];
            flip = (m_wlen[d][c] >= fm);
            for (int k = 0; k < fm; k++) begin
                if (m_win[d][c][k] == m_lvl[d][c]) flip = 1'b0;
            end
            if (flip) m_lvl[d][c] = used;
        end
    endtask

    task automatic check_output(input int d, input logic [2*NCH-1:0] mode);
        logic [NCH-1:0] e_lvl, e_pos, e_neg, e_evt, e_stk;
        logic [NCH-1:0] o_lvl, o_pos, o_neg, o_evt, o_stk;
        logic           o_any;
        string          n;
`ifdef EDGE_DET_COUNTERS_EN
        logic [NCH*CW-1:0] e_cnt, o_cnt;
`endif
        for (int c = 0; c < NCH; c++) begin
            e_lvl[c] = m_lvl[d][c];
            e_pos[c] = m_lvl[d][c] && !m_prv[d][c];
            e_neg[c] = !m_lvl[d][c] && m_prv[d][c];
            e_evt[c] = m_event(d, c, mode);
            e_stk[c] = m_stk[d][c];
`ifdef EDGE_DET_COUNTERS_EN
            e_cnt[c*CW +: CW] = CW'(m_cnt[d][c]);
`endif
        end
        if (d == 0) begin
            n = "A"; o_lvl = bus_a.level_o; o_pos = bus_a.posedge_pulse_o;
            o_neg = bus_a.negedge_pulse_o; o_evt = bus_a.event_o; o_stk = bus_a.sticky_o;
            o_any = bus_a.any_event_o;
`ifdef EDGE_DET_COUNTERS_EN
            o_cnt = bus_a.cnt_o;
`endif
        end else begin
            n = "B"; o_lvl = bus_b.level_o; o_pos = bus_b.posedge_pulse_o;
            o_neg = bus_b.negedge_pulse_o; o_evt = bus_b.event_o; o_stk = bus_b.sticky_o;
            o_any = bus_b.any_event_o;
`ifdef EDGE_DET_COUNTERS_EN
            o_cnt = bus_b.cnt_o;
`endif
        end
        compare({n, ".level"}, o_lvl, e_lvl);
        compare({n, ".posedge"}, o_pos, e_pos);
        compare({n, ".negedge"}, o_neg, e_neg);
        compare({n, ".event"}, o_evt, e_evt);
        compare({n, ".sticky"}, o_stk, e_stk);
        compare({n, ".any_event"}, o_any, |e_evt);
`ifdef EDGE_DET_COUNTERS_EN
        compare({n, ".cnt"}, o_cnt, e_cnt);
`endif
    endtask

    // Called at a falling edge: drive, check the state left by the previous rising edge, then clock.
    task automatic apply_stimulus(input logic [NCH-1:0] sa, input logic [NCH-1:0] sb,
                                  input logic [2*NCH-1:0] mode, input logic [NCH-1:0] clr,
                                  input logic r);
        bus_a.signal_i = sa;
        bus_b.signal_i = sb;
        bus_a.mode_i   = mode;
        bus_b.mode_i   = mode;
        bus_a.clear_i  = clr;
        bus_b.clear_i  = clr;
        rst            = r;
        #1;
        if (model_valid) begin
            check_output(0, mode);
            check_output(1, mode);
        end
        @(posedge clk);
        if (r) begin
            model_reset(0);
            model_reset(1);
            model_valid = 1'b1;
        end else begin
            model_clock(0, sa, mode, clr);
            model_clock(1, sb, mode, clr);
        end
        @(negedge clk);
    endtask

    initial begin
        logic [NCH-1:0]   ra, rb, clr;
        logic [2*NCH-1:0] mode;
        int               ha [NCH];
        int               hb [NCH];
        int               n_pos, n_neg, n_evt, n_lvl;
`ifdef EDGE_DET_COUNTERS_EN
        logic [NCH*CW-1:0] ca;
        logic [NCH-1:0]    tog;
`endif
        @(negedge clk);
        apply_stimulus('0, '0, '0, '0, 1'b1);
        apply_stimulus('0, '0, '0, '0, 1'b1);
        compare("reset.level_a", bus_a.level_o, 64'd0);
        compare("reset.sticky_b", bus_b.sticky_o, 64'd0);
        compare("reset.any_a", bus_a.any_event_o, 64'd0);
        repeat (6) apply_stimulus('0, '0, 8'h55, '0, 1'b0);

        // Rising edge on A ch0 appears two cycles after the first sampling edge.
        for (int i = 0; i < 5; i++) begin
            apply_stimulus(4'b0001, '0, 8'h55, '0, 1'b0);
            compare($sformatf("t1.pos%0d", i), bus_a.posedge_pulse_o[0], 64'(i == 2));
            compare($sformatf("t1.evt%0d", i), bus_a.event_o[0], 64'(i == 2));
        end
        compare("t1.sticky", bus_a.sticky_o[0], 64'd1);

        // Clear coinciding with an event keeps sticky set; a later clear drops it.
        apply_stimulus(4'b0000, '0, 8'h55, 4'b0001, 1'b0);
        repeat (4) apply_stimulus(4'b0000, '0, 8'h55, '0, 1'b0);
        compare("t4.sticky_idle", bus_a.sticky_o[0], 64'd0);
        repeat (3) apply_stimulus(4'b0001, '0, 8'h55, '0, 1'b0);
        compare("t4.evt", bus_a.event_o[0], 64'd1);
        apply_stimulus(4'b0001, '0, 8'h55, 4'b0001, 1'b0);
        compare("t4.sticky_set", bus_a.sticky_o[0], 64'd1);
        apply_stimulus(4'b0001, '0, 8'h55, 4'b0001, 1'b0);
        compare("t4.sticky_clr", bus_a.sticky_o[0], 64'd0);

        // Fall-only mode on ch1, then mode off: pulses remain, events do not.
        apply_stimulus(4'b0001, '0, 8'h08, 4'hF, 1'b0);
        n_pos = 0; n_neg = 0; n_evt = 0;
        for (int i = 0; i < 12; i++) begin
            apply_stimulus((i < 6) ? 4'b0011 : 4'b0001, '0, 8'h08, '0, 1'b0);
            n_pos += int'(bus_a.posedge_pulse_o[1]);
            n_neg += int'(bus_a.negedge_pulse_o[1]);
            n_evt += int'(bus_a.event_o[1] & bus_a.negedge_pulse_o[1]) + int'(bus_a.event_o[1]);
        end
        compare("t3.pos_cnt", 64'(n_pos), 64'd1);
        compare("t3.neg_cnt", 64'(n_neg), 64'd1);
        compare("t3.evt_on_fall", 64'(n_evt), 64'd2);
        compare("t3.sticky", bus_a.sticky_o[1], 64'd1);
        apply_stimulus(4'b0001, '0, 8'h00, 4'b0010, 1'b0);
        n_pos = 0; n_evt = 0;
        for (int i = 0; i < 12; i++) begin
            apply_stimulus((i < 6) ? 4'b0011 : 4'b0001, '0, 8'h00, '0, 1'b0);
            n_pos += int'(bus_a.posedge_pulse_o[1]) + int'(bus_a.negedge_pulse_o[1]);
            n_evt += int'(bus_a.event_o[1]) + int'(bus_a.sticky_o[1]);
        end
        compare("t3.off_pulses", 64'(n_pos), 64'd2);
        compare("t3.off_events", 64'(n_evt), 64'd0);

        // Filtered instance: a 3-cycle glitch is rejected, a 4-cycle pulse is accepted.
        n_pos = 0; n_lvl = 0;
        for (int i = 0; i < 13; i++) begin
            apply_stimulus(4'b0001, (i < 3) ? 4'b0001 : 4'b0000, 8'h55, '0, 1'b0);
            n_pos += int'(bus_b.posedge_pulse_o[0]);
            n_lvl += int'(bus_b.level_o[0]);
        end
        compare("t2.glitch_pos", 64'(n_pos), 64'd0);
        compare("t2.glitch_lvl", 64'(n_lvl), 64'd0);
        n_pos = 0; n_neg = 0;
        for (int i = 0; i < 14; i++) begin
            apply_stimulus(4'b0001, (i < 4) ? 4'b0001 : 4'b0000, 8'h55, '0, 1'b0);
            n_pos += int'(bus_b.posedge_pulse_o[0]);
            n_neg += int'(bus_b.negedge_pulse_o[0]);
        end
        compare("t2.pulse_pos", 64'(n_pos), 64'd1);
        compare("t2.pulse_neg", 64'(n_neg), 64'd1);

        // Reset in the middle of a filter count; the edge reappears L=4 cycles after release.
        repeat (2) apply_stimulus(4'b0001, 4'b0001, 8'h55, '0, 1'b0);
        apply_stimulus(4'b0001, 4'b0001, 8'h55, '0, 1'b1);
        compare("t5.level_b", bus_b.level_o, 64'd0);
        compare("t5.pos_b", bus_b.posedge_pulse_o, 64'd0);
        compare("t5.sticky_b", bus_b.sticky_o, 64'd0);
        compare("t5.any_a", bus_a.any_event_o, 64'd0);
        for (int i = 1; i <= 7; i++) begin
            apply_stimulus(4'b0001, 4'b0001, 8'h55, '0, 1'b0);
            compare($sformatf("t5.pos%0d", i), bus_b.posedge_pulse_o[0], 64'(i == 5));
        end

`ifdef EDGE_DET_COUNTERS_EN
        // Counter saturation at 15 after 17 events, then clear together with an event.
        repeat (5) apply_stimulus(4'b0000, 4'b0000, 8'h03, '0, 1'b0);
        apply_stimulus(4'b0000, 4'b0000, 8'h03, 4'b0001, 1'b0);
        tog = 4'b0000;
        for (int t = 0; t < 17; t++) begin
            tog[0] = ~tog[0];
            repeat (2) apply_stimulus(tog, 4'b0000, 8'h03, '0, 1'b0);
        end
        repeat (5) apply_stimulus(tog, 4'b0000, 8'h03, '0, 1'b0);
        ca = bus_a.cnt_o;
        compare("t6.cnt_sat", ca[CW-1:0], 64'd15);
        tog[0] = ~tog[0];
        repeat (3) apply_stimulus(tog, 4'b0000, 8'h03, '0, 1'b0);
        apply_stimulus(tog, 4'b0000, 8'h03, 4'b0001, 1'b0);
        ca = bus_a.cnt_o;
        compare("t6.cnt_clr_evt", ca[CW-1:0], 64'd1);
`endif

        // Randomized traffic with per-channel hold times straddling the filter length.
        ra = '0; rb = '0; mode = 8'h55;
        for (int c = 0; c < NCH; c++) begin
            ha[c] = $urandom_range(1, 7);
            hb[c] = $urandom_range(1, 7);
        end
        for (int cyc = 0; cyc < 600; cyc++) begin
            for (int c = 0; c < NCH; c++) begin
                if (ha[c] == 0) begin ra[c] = ~ra[c]; ha[c] = $urandom_range(1, 7); end
                else ha[c]--;
                if (hb[c] == 0) begin rb[c] = ~rb[c]; hb[c] = $urandom_range(1, 7); end
                else hb[c]--;
            end
            if (cyc % 20 == 0) mode = 8'($urandom);
            clr = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'b0000;
            apply_stimulus(ra, rb, mode, clr, $urandom_range(0, 199) == 0);
        end

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end
endmodule
